cpu_sequencer: RTL

//   Control sequencer upstream of dp_controller. Latches a 16-bit instruction, decodes it, and steps

---
 rtl/dp_pkg.sv | 38 +++
 rtl/cpu_sequencer_decoder.sv | 54 +++++
 rtl/cpu_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared datapath package: state codes, instruction classes,
// opcode/op fields and datapath select codes.
package dp_pkg;

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_WRITE_IMM = 4'd2,
    S_LOAD_AB   = 4'd3,
    S_LOAD_B    = 4'd4,
    S_LOAD_C    = 4'd5,
    S_WRITE_C   = 4'd6,
    S_LOAD_S    = 4'd7
  } state_t;

  typedef enum logic [2:0] {
    C_MOV_IMM,
    C_MOV_REG,
    C_ALU_AB,
    C_CMP,
    C_MVN,
    C_ILLEGAL
  } iclass_t;

  localparam logic SEL_C   = 1'b0;
  localparam logic SEL_IMM = 1'b1;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

endpackage

// File: rtl/cpu_sequencer_decoder.sv
// Combinational instruction decoder.
// ir in; register fields, alu_op, shift, immediates, class out.
module instr_decoder
  import dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic [15:0]        ir,
  output logic [RADDR_W-1:0] rn,
  output logic [RADDR_W-1:0] rd,
  output logic [RADDR_W-1:0] rm,
  output logic [1:0]         alu_op,
  output logic [1:0]         shift,
  output logic [DATA_W-1:0]  sximm8,
  output logic [DATA_W-1:0]  sximm5,
  output iclass_t            iclass
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc    = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = RADDR_W'(ir[10:8]);
  assign rd     = RADDR_W'(ir[7:5]);
  assign rm     = RADDR_W'(ir[2:0]);
  assign shift  = ir[4:3];
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

  always_comb begin
    iclass = C_ILLEGAL;
    unique case (1'b1)
      (opc == OPC_MOV && op == OP_MOV_IMM):
        iclass = C_MOV_IMM;
      (opc == OPC_MOV && op == OP_MOV_REG):
        iclass = C_MOV_REG;
      (opc == OPC_ALU && op == OP_ADD),
      (opc == OPC_ALU && op == OP_AND):
        iclass = C_ALU_AB;
      (opc == OPC_ALU && op == OP_CMP):
        iclass = C_CMP;
      (opc == OPC_ALU && op == OP_MVN):
        iclass = C_MVN;
      default:
        iclass = C_ILLEGAL;
    endcase
  end

  // MOV-reg moves Rm through the ALU as Rm + 0
  assign alu_op = (iclass == C_MOV_REG) ? OP_ADD : op;

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer: holds IR, steps the datapath state.
// s/load/in in; state, w, illegal and decoded fields out.
module cpu_sequencer
  import dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic               load,
  input  logic [15:0]        in,
  output logic [3:0]         state,
  output logic               w,
  output logic               illegal,
  output logic [RADDR_W-1:0] readnum_a,
  output logic [RADDR_W-1:0] readnum_b,
  output logic [RADDR_W-1:0] writenum,
  output logic [1:0]         alu_op,
  output logic [1:0]         shift,
  output logic [DATA_W-1:0]  sximm8,
  output logic [DATA_W-1:0]  sximm5
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        ill_q, ill_d;

  logic [RADDR_W-1:0] rn, rd, rm;
  iclass_t            iclass;

  instr_decoder #(
    .DATA_W (DATA_W),
    .RADDR_W(RADDR_W)
  ) u_dec (
    .ir    (ir_q),
    .rn    (rn),
    .rd    (rd),
    .rm    (rm),
    .alu_op(alu_op),
    .shift (shift),
    .sximm8(sximm8),
    .sximm5(sximm5),
    .iclass(iclass)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ill_d   = 1'b0;
    case (state_q)
      S_WAIT: begin
        // IR is only writable while idle
        if (load) ir_d = in;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (iclass)
          C_MOV_IMM: state_d = S_WRITE_IMM;
          C_MOV_REG,
          C_MVN:     state_d = S_LOAD_B;
          C_ALU_AB,
          C_CMP:     state_d = S_LOAD_AB;
          default: begin
            state_d = S_WAIT;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_LOAD_AB:
        state_d = (iclass == C_CMP) ? S_LOAD_S : S_LOAD_C;
      S_LOAD_B:    state_d = S_LOAD_C;
      S_LOAD_C:    state_d = S_WRITE_C;
      S_WRITE_IMM: state_d = S_WAIT;
      S_WRITE_C:   state_d = S_WAIT;
      S_LOAD_S:    state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  assign state     = state_q;
  assign w         = (state_q == S_WAIT);
  assign illegal   = ill_q;
  assign readnum_a = rn;
  assign readnum_b = rm;
  assign writenum  = (state_q == S_WRITE_IMM) ? rn : rd;

endmodule
